// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: multi-cycle mul/div sequencer that owns the HI/LO pair.
// Define MD_FAST_MUL_EN for a single-cycle mult/multu datapath.
module hilo_md_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             md_start,
    input  logic [5:0]       md_op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    output logic             stallreq,
    output logic             busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    localparam int CW = $clog2(WIDTH) + 1;

`ifdef MD_FAST_MUL_EN
    typedef enum logic [1:0] {IDLE, DIV_RUN, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;
`endif

    state_t state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] rem_q, rem_d, quot_q, quot_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic qneg_q, qneg_d, rneg_q, rneg_d;

    logic op_ok, op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo;
    logic is_div, is_mul, sgn, s_neg, iter_req;
    logic [WIDTH-1:0] abs1, abs2;

    assign op_ok    = (md_op != '0) && ((md_op & (md_op - 6'd1)) == '0);
    assign op_div   = op_ok & md_op[5];
    assign op_divu  = op_ok & md_op[4];
    assign op_mult  = op_ok & md_op[3];
    assign op_multu = op_ok & md_op[2];
    assign op_mthi  = op_ok & md_op[1];
    assign op_mtlo  = op_ok & md_op[0];

    assign is_div = op_div | op_divu;
    assign is_mul = op_mult | op_multu;
    assign sgn    = op_div | op_mult;
    assign s_neg  = sgn & (src1[WIDTH-1] ^ src2[WIDTH-1]);
    assign abs1   = (sgn & src1[WIDTH-1]) ? -src1 : src1;
    assign abs2   = (sgn & src2[WIDTH-1]) ? -src2 : src2;

`ifdef MD_FAST_MUL_EN
    assign iter_req = is_div;
`else
    assign iter_req = is_div | is_mul;
`endif

    // Restoring divide step: {rem,quot} shifts left, quotient bits enter at LSB
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] dstep_rem, dstep_quot;

    assign rem_sh     = {rem_q, quot_q[WIDTH-1]};
    assign diff       = rem_sh - {1'b0, dvs_q};
    assign dstep_rem  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dstep_quot = {quot_q[WIDTH-2:0], ~diff[WIDTH]};

`ifdef MD_FAST_MUL_EN
    logic [2*WIDTH-1:0] fprod;
    assign fprod = {{WIDTH{1'b0}}, abs1} * {{WIDTH{1'b0}}, abs2};
`else
    // Shift-add multiply: {rem,quot} holds {partial, multiplier}, shifts right
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mstep;
    assign msum  = {1'b0, rem_q} + (quot_q[0] ? {1'b0, dvs_q} : '0);
    assign mstep = {msum, quot_q[WIDTH-1:1]};
`endif

    assign busy     = (state_q == DIV_RUN)
`ifndef MD_FAST_MUL_EN
                    | (state_q == MUL_RUN)
`endif
                    ;
    assign md_done  = (state_q == DONE);
    assign stallreq = rst & (((state_q == IDLE) & md_start & iter_req & ~flush)
                    | busy);
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        unique case (state_q)
            IDLE: begin
                if (md_start && !flush) begin
                    unique case (1'b1)
                        is_div: begin
                            rem_d   = '0;
                            quot_d  = abs1;
                            dvs_d   = abs2;
                            cnt_d   = '0;
                            qneg_d  = s_neg & (src2 != '0);
                            rneg_d  = sgn & src1[WIDTH-1];
                            state_d = DIV_RUN;
                        end
                        is_mul: begin
`ifdef MD_FAST_MUL_EN
                            {hi_d, lo_d} = s_neg ? -fprod : fprod;
`else
                            rem_d   = '0;
                            quot_d  = abs2;
                            dvs_d   = abs1;
                            cnt_d   = '0;
                            qneg_d  = s_neg;
                            state_d = MUL_RUN;
`endif
                        end
                        op_mthi: hi_d = src1;
                        op_mtlo: lo_d = src1;
                        default: ;
                    endcase
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = dstep_rem;
                    quot_d = dstep_quot;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_d    = rneg_q ? -dstep_rem : dstep_rem;
                        lo_d    = qneg_q ? -dstep_quot : dstep_quot;
                        state_d = DONE;
                    end
                end
            end
`ifndef MD_FAST_MUL_EN
            MUL_RUN: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    rem_d  = mstep[2*WIDTH-1:WIDTH];
                    quot_d = mstep[WIDTH-1:0];
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        {hi_d, lo_d} = qneg_q ? -mstep : mstep;
                        state_d      = DONE;
                    end
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end
endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multi-cycle multiply/divide sequencer that owns the HI/LO register pair. It sits beside EX and accepts decoded `div/divu/mult/multu/mthi/mtlo` operations with their rs/rt operands. It iterates a shared shift-subtract/shift-add datapath over 32 steps and holds the pipeline through `stallreq` until the result is written to HI/LO. It also serves `mfhi/mflo` reads through `hi_o`/`lo_o`.

## Interface
- `WIDTH`, 32, operand and HI/LO width; iteration counter is `$clog2(WIDTH)+1` bits
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  abort in-flight operation
- `md_start`  in  1  level request from EX, held stable while `stallreq`=1
- `md_op`  in  6  one-hot `{div, divu, mult, multu, mthi, mtlo}`, valid with `md_start`
- `src1`  in  WIDTH  rs value (dividend / multiplicand / mthi-mtlo data)
- `src2`  in  WIDTH  rt value (divisor / multiplier)
- `stallreq`  out  1  pipeline hold request to the stall controller
- `busy`  out  1  FSM in DIV_RUN or MUL_RUN
- `md_done`  out  1  one-cycle pulse, result just written
- `hi_o`  out  WIDTH  current HI
- `lo_o`  out  WIDTH  current LO

## Operation
- States: IDLE, DIV_RUN, MUL_RUN, DONE. Reset (`rst`=0) forces IDLE and clears HI, LO, the counter, and the working registers. All outputs are 0 during reset.
- IDLE, `md_start` & (`div`|`divu`): latch |src1| and |src2| (raw values for `divu`), remainder accumulator=0, counter=0, record quotient sign `src1[31]^src2[31]` and remainder sign `src1[31]` (both 0 for `divu`), then go to DIV_RUN.
- DIV_RUN: each cycle performs one restoring step: shift {rem,quot} left 1, trial-subtract divisor, set quotient bit if no borrow. At counter = WIDTH-1, write HI=remainder and LO=quotient, each sign-corrected, then go to DONE.
- Divide by zero: the FSM runs the normal 32 steps with no sign correction and no exception. The result is HI=src1 (raw) and LO=0xFFFFFFFF.
- IDLE, `md_start` & (`mult`|`multu`): latch operands (absolute values for `mult`), then go to MUL_RUN. Each step adds the shifted multiplicand when the multiplier LSB is 1. After 32 steps, write the two's-complement-negated 64-bit product if signs differ; {HI,LO}=product. Then go to DONE.
- IDLE, `md_start` & `mthi`: HI<=src1 at the next edge. `mtlo` sets LO<=src1 the same way. FSM stays IDLE; no stall and no `md_done`.
- DONE: `md_done`=1 and `stallreq`=0. The next edge returns to IDLE unconditionally. The still-asserted `md_start` of the finished instruction is ignored in DONE.
- `flush`=1 in any state: go to IDLE at the next edge; HI/LO are unchanged. `flush` has priority over `md_start` in IDLE.
- `md_op` with zero or multiple bits set: ignored, FSM stays IDLE, `stallreq`=0.

## Timing
- `stallreq` = (IDLE & `md_start` & (div|divu|mult|multu) & ~`flush`) | `busy`. It is combinational, so the request is seen in the same cycle T.
- Divide or iterative multiply accepted at T:
  - RUN occupies T+1..T+32.
  - HI/LO are written at the edge ending T+32.
  - DONE occupies T+33, with `hi_o`/`lo_o` showing the new values.
  - `stallreq` is high for T..T+32 (33 cycles). IDLE resumes at T+34.
- `mthi`/`mtlo`: new value on `hi_o`/`lo_o` at T+1.
- `hi_o`/`lo_o` are direct register outputs; HI/LO writes in DONE are never bypassed.
- Reset asserted mid-operation: immediate asynchronous return to IDLE; `stallreq` drops without waiting for a clock edge.

## Configuration
- `MD_FAST_MUL_EN` defined: `mult`/`multu` use a single-cycle 64-bit signed/unsigned product. {HI,LO} are written at the edge ending T, `stallreq` stays 0, no `md_done` is raised, and MUL_RUN is not generated.
- Undefined: the 32-step iterative multiply above, taking 33 stall cycles.

## Test plan
- `divu` src1=100, src2=7 -> `stallreq` high exactly 33 cycles; in DONE HI=2, LO=14, `md_done` 1 cycle.
- `div` src1=0xFFFFFFF9 (-7), src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; `div` src1=5, src2=0 -> HI=5, LO=0xFFFFFFFF.
- `mult` 0xFFFFFFFF×2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; `multu` same operands -> HI=1, LO=0xFFFFFFFE. Run with and without `MD_FAST_MUL_EN`; check the stall count is 33 vs 0.
- HI=LO=0x12345678, start `divu` 100/7, pulse `flush` at T+10 -> IDLE at T+11, `stallreq` 0, HI/LO still 0x12345678.
- `mthi` src1=0xA5A5A5A5 then `mtlo` src1=0x5A5A5A5A on consecutive cycles -> `hi_o`/`lo_o` update at T+1/T+2, `stallreq` never high.
- `rst` driven low mid-DIV_RUN between clock edges -> `stallreq`, `busy`, `hi_o`, `lo_o` go 0 immediately. A fresh `divu` 9/3 after release gives LO=3, HI=0.
